// File: rtl/clk_sel_pkg.sv
// Shared types and constants for the clock-select controller.
package clk_sel_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CHECK  = 2'd1,
    SWITCH = 2'd2,
    SETTLE = 2'd3
  } state_t;

  localparam logic SEL_CLKA = 1'b0;
  localparam logic SEL_CLKB = 1'b1;

endpackage

// File: rtl/tog_sync.sv
// Synchronises a foreign-domain divide-by-2 toggle and flags every transition.
module tog_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tog,
  output logic edge_c
);

  logic [SYNC_STAGES-1:0] sync;
  logic                   hist;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync <= '0;
      hist <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], tog};
      hist <= sync[SYNC_STAGES-1];
    end
  end

  // Rising and falling transitions both count as evidence of a live clock.
  assign edge_c = sync[SYNC_STAGES-1] ^ hist;

endmodule

// File: rtl/clk_sel_ctrl.sv
// Owns clkmux2.select: proves the target clock alive, switches, then waits for the mux to settle.
module clk_sel_ctrl
  import clk_sel_pkg::*;
#(
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned WIN_CYCLES    = 64,
  parameter int unsigned MIN_EDGES     = 4,
  parameter int unsigned SETTLE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req_valid,
  input  logic req_sel,
  output logic req_ready,
  input  logic clka_tog,
  input  logic clkb_tog,
  output logic select,
  output logic busy,
  output logic done,
  output logic err
);

  localparam int unsigned WIN_W    = $clog2(WIN_CYCLES);
  localparam int unsigned EDGE_W   = $clog2(MIN_EDGES + 1);
  localparam int unsigned SETTLE_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  state_t              state;
  logic                tgt;
  logic [WIN_W-1:0]    win_cnt;
  logic [EDGE_W-1:0]   edge_cnt;
  logic [SETTLE_W-1:0] settle_cnt;

  logic                clka_edge_c;
  logic                clkb_edge_c;
  logic                tgt_edge_c;
  logic [EDGE_W-1:0]   edge_nxt_c;
  logic                win_last_c;
  logic                settle_last_c;

  tog_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_a (
    .clk    (clk),
    .rst_n  (rst_n),
    .tog    (clka_tog),
    .edge_c (clka_edge_c)
  );

  tog_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_b (
    .clk    (clk),
    .rst_n  (rst_n),
    .tog    (clkb_tog),
    .edge_c (clkb_edge_c)
  );

  // Only the target's toggle matters; count saturates so it never wraps.
  assign tgt_edge_c    = (tgt == SEL_CLKB) ? clkb_edge_c : clka_edge_c;
  assign edge_nxt_c    = (tgt_edge_c && (edge_cnt < EDGE_W'(MIN_EDGES))) ?
                         edge_cnt + EDGE_W'(1) : edge_cnt;
  assign win_last_c    = (win_cnt == WIN_W'(WIN_CYCLES - 1));
  assign settle_last_c = (settle_cnt == SETTLE_W'(SETTLE_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      select     <= SEL_CLKA;
      tgt        <= SEL_CLKA;
      req_ready  <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      win_cnt    <= '0;
      edge_cnt   <= '0;
      settle_cnt <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            if (req_sel == select) begin
              done <= 1'b1;
            end else begin
              tgt       <= req_sel;
              win_cnt   <= '0;
              edge_cnt  <= '0;
              state     <= CHECK;
              req_ready <= 1'b0;
              busy      <= 1'b1;
            end
          end
        end
        CHECK: begin
          edge_cnt <= edge_nxt_c;
          if (!win_last_c) begin
            win_cnt <= win_cnt + WIN_W'(1);
          end else if (edge_nxt_c >= EDGE_W'(MIN_EDGES)) begin
            state <= SWITCH;
          end else begin
            err       <= 1'b1;
            state     <= IDLE;
            req_ready <= 1'b1;
            busy      <= 1'b0;
          end
        end
        SWITCH: begin
          select     <= tgt;
          settle_cnt <= '0;
          state      <= SETTLE;
        end
        SETTLE: begin
          if (!settle_last_c) begin
            settle_cnt <= settle_cnt + SETTLE_W'(1);
          end else begin
            done      <= 1'b1;
            state     <= IDLE;
            req_ready <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_clk_sel_ctrl.sv
// Scoreboard bench for clk_sel_ctrl: expected done/err events queued at accept, matched on output.
module tb_clk_sel_ctrl;

  localparam int LAT_DONE = 81;
  localparam int LAT_ERR  = 64;
  localparam int LAT_NOOP = 0;
  localparam int K_DONE   = 1;
  localparam int K_ERR    = 2;

  logic clk;
  logic rst_n;
  logic req_valid;
  logic req_sel;
  logic req_ready;
  logic clka_tog;
  logic clkb_tog;
  logic select;
  logic busy;
  logic done;
  logic err;

  logic a_gen, b_gen, b_man, b_run;
  int   a_per, b_per;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  typedef struct {
    int   kind;
    int   cyc;
    logic sel;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  clk_sel_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_sel   (req_sel),
    .req_ready (req_ready),
    .clka_tog  (clka_tog),
    .clkb_tog  (clkb_tog),
    .select    (select),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    a_gen = 1'b0;
    #3;
    forever begin
      #(a_per);
      a_gen = ~a_gen;
    end
  end

  initial begin
    b_gen = 1'b0;
    #7;
    forever begin
      #(b_per);
      b_gen = ~b_gen;
    end
  end

  assign clka_tog = a_gen;
  assign clkb_tog = b_run ? b_gen : b_man;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk_eq(input string tag, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Every done/err pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (done === 1'b1 && err === 1'b1) chk_eq("done_err_together", 1, 0);
      if (done === 1'b1 || err === 1'b1) begin
        if (sb.size() == 0) begin
          chk_eq("unexpected_evt", done ? K_DONE : K_ERR, 0);
        end else begin
          mon_e = sb.pop_front();
          chk_eq("evt_kind", done ? K_DONE : K_ERR, mon_e.kind);
          chk_eq("evt_cyc", cyc, mon_e.cyc);
          chk_eq("evt_sel", int'(select), int'(mon_e.sel));
        end
      end
    end
  end

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic send(input logic sel, input int kind, input int lat,
                      input logic esel, output int acc);
    int t;
    t = 0;
    @(negedge clk);
    while (req_ready !== 1'b1 && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (req_ready !== 1'b1) chk_eq("ready_timeout", 0, 1);
    req_valid = 1'b1;
    req_sel   = sel;
    @(posedge clk);
    #1;
    acc       = cyc;
    req_valid = 1'b0;
    if (kind != 0) sb.push_back('{kind: kind, cyc: acc + lat, sel: esel});
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sb.size() != 0 && t < 400) begin
      @(negedge clk);
      t++;
    end
    if (sb.size() != 0) begin
      chk_eq("drain_timeout", sb.size(), 0);
      sb.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int   acc;
    logic cur;
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_sel   = 1'b0;
    b_run     = 1'b1;
    b_man     = 1'b0;
    a_per     = 20;
    b_per     = 30;

    // Reset values, then quiet outputs.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_eq("rst_select", int'(select), 0);
    chk_eq("rst_ready", int'(req_ready), 1);
    chk_eq("rst_busy", int'(busy), 0);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk_eq("idle_quiet", int'(done | err), 0);
    end

    // Switch to clkb with its toggle moving every 3 clk.
    send(1'b1, K_DONE, LAT_DONE, 1'b1, acc);
    wait_cyc(acc + 64);
    chk_eq("sel_before_switch", int'(select), 0);
    chk_eq("busy_in_check", int'(busy), 1);
    wait_cyc(acc + 65);
    chk_eq("sel_after_switch", int'(select), 1);
    drain();
    chk_eq("ready_after_done", int'(req_ready), 1);

    // Back to clka, then request a dead clkb.
    send(1'b0, K_DONE, LAT_DONE, 1'b0, acc);
    drain();
    b_run = 1'b0;
    b_man = 1'b0;
    repeat (6) @(negedge clk);
    send(1'b1, K_ERR, LAT_ERR, 1'b0, acc);
    drain();
    chk_eq("err_select_kept", int'(select), 0);
    chk_eq("err_ready", int'(req_ready), 1);

    // No-op request.
    send(1'b0, K_DONE, LAT_NOOP, 1'b0, acc);
    chk_eq("noop_busy", int'(busy), 0);
    drain();
    chk_eq("noop_select", int'(select), 0);

    // Reset in the middle of SETTLE.
    b_run = 1'b1;
    repeat (4) @(negedge clk);
    send(1'b1, 0, 0, 1'b1, acc);
    wait_cyc(acc + 70);
    chk_eq("settle_select", int'(select), 1);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk_eq("abort_select", int'(select), 0);
    chk_eq("abort_busy", int'(busy), 0);
    chk_eq("abort_ready", int'(req_ready), 1);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);

    // Opposite request held through busy is taken only once IDLE returns.
    a_per = $urandom_range(11, 60);
    b_per = $urandom_range(11, 60);
    send(1'b1, K_DONE, LAT_DONE, 1'b1, acc);
    sb.push_back('{kind: K_DONE, cyc: acc + 82 + LAT_DONE, sel: 1'b0});
    req_valid = 1'b1;
    req_sel   = 1'b0;
    wait_cyc(acc + 80);
    chk_eq("held_busy", int'(busy), 1);
    wait_cyc(acc + 82);
    chk_eq("held_accepted", int'(busy), 1);
    req_valid = 1'b0;
    drain();

    // Exactly MIN_EDGES transitions (both directions) pass; one fewer fails.
    b_run = 1'b0;
    b_man = 1'b0;
    repeat (6) @(negedge clk);
    send(1'b1, K_DONE, LAT_DONE, 1'b1, acc);
    for (int i = 0; i < 4; i++) begin
      wait_cyc(acc + 5 + 10 * i);
      b_man = ~b_man;
    end
    drain();
    send(1'b0, K_DONE, LAT_DONE, 1'b0, acc);
    drain();
    send(1'b1, K_ERR, LAT_ERR, 1'b0, acc);
    for (int i = 0; i < 3; i++) begin
      wait_cyc(acc + 5 + 10 * i);
      b_man = ~b_man;
    end
    drain();

    // Random toggle rates and phases.
    b_run = 1'b1;
    cur   = select;
    for (int k = 0; k < 4; k++) begin
      a_per = $urandom_range(11, 60);
      b_per = $urandom_range(11, 60);
      repeat ($urandom_range(1, 7)) @(negedge clk);
      cur = ~cur;
      send(cur, K_DONE, LAT_DONE, cur, acc);
      drain();
      chk_eq("rand_select", int'(select), int'(cur));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
